// File: rtl/chacha_pkg.sv
// Shared types, constants and round index tables for the ChaCha block controller.
package chacha_pkg;

   typedef logic [31:0] word_t;
   typedef word_t state_t [16];

   // "expand 32-byte k" words loaded into state words 0-3
   localparam word_t SIGMA [4] = '{32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      FINAL = 2'd2,
      DONE  = 2'd3
   } fsm_e;

   // (a,b,c,d) state indices for each of the four parallel quarter-rounds
   localparam logic [3:0] COL_IDX [4][4] = '{
      '{4'd0, 4'd4, 4'd8,  4'd12},
      '{4'd1, 4'd5, 4'd9,  4'd13},
      '{4'd2, 4'd6, 4'd10, 4'd14},
      '{4'd3, 4'd7, 4'd11, 4'd15}
   };

   localparam logic [3:0] DIAG_IDX [4][4] = '{
      '{4'd0, 4'd5, 4'd10, 4'd15},
      '{4'd1, 4'd6, 4'd11, 4'd12},
      '{4'd2, 4'd7, 4'd8,  4'd13},
      '{4'd3, 4'd4, 4'd9,  4'd14}
   };

endpackage

// File: rtl/chacha_block_ctrl_round.sv
// ChaCha quarter-round datapath (purely combinational).
module round
   import chacha_pkg::*;
(
   input  word_t a_i,
   input  word_t b_i,
   input  word_t c_i,
   input  word_t d_i,
   output word_t a_o,
   output word_t b_o,
   output word_t c_o,
   output word_t d_o
);

   word_t a1, b1, c1, d1, d1r, b1r, a2, b2, c2, d2, d2r, b2r;

   // add/xor/rotate chain with rotations 16, 12, 8, 7
   always_comb begin
      a1  = a_i + b_i;
      d1  = d_i ^ a1;
      d1r = {d1[15:0], d1[31:16]};
      c1  = c_i + d1r;
      b1  = b_i ^ c1;
      b1r = {b1[19:0], b1[31:20]};
      a2  = a1 + b1r;
      d2  = d1r ^ a2;
      d2r = {d2[23:0], d2[31:24]};
      c2  = c1 + d2r;
      b2  = b1r ^ c2;
      b2r = {b2[24:0], b2[31:25]};
   end

   assign a_o = a2;
   assign b_o = b2r;
   assign c_o = c2;
   assign d_o = d2r;

endmodule

// File: rtl/chacha_block_ctrl.sv
// ChaCha block sequencer: load, NUM_ROUNDS rounds, feed-forward, valid/ready output.
module chacha_block_ctrl
   import chacha_pkg::*;
#(
   parameter int unsigned NUM_ROUNDS = 20,
   parameter int unsigned CNT_W      = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [255:0] key,
   input  logic [31:0]  counter,
   input  logic [95:0]  nonce,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [511:0] keystream,
   output logic         busy
);

   if (NUM_ROUNDS == 0 || (NUM_ROUNDS % 2) != 0) begin : g_bad_rounds
      $error("chacha_block_ctrl: NUM_ROUNDS must be even and nonzero");
   end
   if ((64'(1) << CNT_W) <= 64'(NUM_ROUNDS)) begin : g_bad_cnt_w
      $error("chacha_block_ctrl: CNT_W too narrow for NUM_ROUNDS");
   end

   fsm_e             state_q, state_d;
   logic [CNT_W-1:0] rcnt_q, rcnt_d;
   logic [511:0]     ks_q, ks_d;
   state_t           work_q, work_d;
   state_t           init_q, init_d;
   state_t           load_s;
   logic [3:0]       sel_idx [4][4];
   word_t            qin  [4][4];
   word_t            qout [4][4];

   // initial state assembled from constants and the input buses
   always_comb begin
      for (int i = 0; i < 4; i++) load_s[i]      = SIGMA[i];
      for (int i = 0; i < 8; i++) load_s[4 + i]  = key[32*i +: 32];
      load_s[12] = counter;
      for (int j = 0; j < 3; j++) load_s[13 + j] = nonce[32*j +: 32];
   end

   // column rounds on even rcnt, diagonal rounds on odd rcnt
   always_comb begin
      for (int q = 0; q < 4; q++) begin
         for (int k = 0; k < 4; k++) begin
            sel_idx[q][k] = rcnt_q[0] ? DIAG_IDX[q][k] : COL_IDX[q][k];
            qin[q][k]     = work_q[sel_idx[q][k]];
         end
      end
   end

   for (genvar q = 0; q < 4; q++) begin : g_qr
      round u_round (
         .a_i (qin[q][0]),
         .b_i (qin[q][1]),
         .c_i (qin[q][2]),
         .d_i (qin[q][3]),
         .a_o (qout[q][0]),
         .b_o (qout[q][1]),
         .c_o (qout[q][2]),
         .d_o (qout[q][3])
      );
   end

   // next-state logic for the FSM, round counter and datapath registers
   always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      ks_d    = ks_q;
      work_d  = work_q;
      init_d  = init_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               work_d  = load_s;
               init_d  = load_s;
               rcnt_d  = '0;
               state_d = ROUND;
            end
         end
         ROUND: begin
            for (int q = 0; q < 4; q++) begin
               for (int k = 0; k < 4; k++) work_d[sel_idx[q][k]] = qout[q][k];
            end
            rcnt_d = rcnt_q + CNT_W'(1);
            if (rcnt_q == CNT_W'(NUM_ROUNDS - 1)) state_d = FINAL;
         end
         FINAL: begin
            for (int i = 0; i < 16; i++) ks_d[32*i +: 32] = work_q[i] + init_q[i];
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // control registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rcnt_q  <= '0;
         ks_q    <= '0;
      end else begin
         state_q <= state_d;
         rcnt_q  <= rcnt_d;
         ks_q    <= ks_d;
      end
   end

   // working and feed-forward state; only meaningful after a load
   always_ff @(posedge clk) begin
      work_q <= work_d;
      init_q <= init_d;
   end

   // handshake flags decode the FSM register; rst masks them so it wins over any handshake
   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = (state_q == DONE) && !rst;
   assign busy      = (state_q != IDLE) && !rst;
   assign keystream = ks_q;

endmodule

// File: tb/tb_chacha_block_ctrl.sv
// Self-checking bench for chacha_block_ctrl against a software ChaCha model.
module tb_chacha_block_ctrl;

   localparam int NR  = 20;
   localparam int NR8 = 8;

   localparam logic [255:0] RFC_KEY = {32'h1f1e1d1c, 32'h1b1a1918, 32'h17161514, 32'h13121110,
                                       32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100};
   localparam logic [95:0]  RFC_NONCE = {32'h00000000, 32'h4a000000, 32'h09000000};
   localparam logic [511:0] RFC_KS = {
      32'h4e3c50a2, 32'he883d0cb, 32'hb94e16de, 32'hd19c12b5,
      32'ha2028bd9, 32'h05d7c214, 32'h09aa9f07, 32'h466482d2,
      32'h4e6cd4c3, 32'h9aaa2204, 32'h0368c033, 32'hc7f4d1c7,
      32'hc47120a3, 32'h1fdd0f50, 32'h15593bd1, 32'he4e7f110};

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_ready, out_valid, out_ready, busy;
   logic [255:0] key;
   logic [31:0]  counter;
   logic [95:0]  nonce;
   logic [511:0] keystream;
   logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
   logic [511:0] b_keystream;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   chacha_block_ctrl #(.NUM_ROUNDS(NR), .CNT_W(5)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .key(key), .counter(counter), .nonce(nonce),
      .out_valid(out_valid), .out_ready(out_ready), .keystream(keystream), .busy(busy)
   );

   chacha_block_ctrl #(.NUM_ROUNDS(NR8), .CNT_W(4)) dut8 (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .key(key), .counter(counter), .nonce(nonce),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .keystream(b_keystream), .busy(b_busy)
   );

   // ---------------- reference model ----------------
   function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
      return (x << n) | (x >> (32 - n));
   endfunction

   function automatic logic [127:0] qr(input logic [31:0] a, b, c, d);
      a = a + b; d = rotl(d ^ a, 16);
      c = c + d; b = rotl(b ^ c, 12);
      a = a + b; d = rotl(d ^ a, 8);
      c = c + d; b = rotl(b ^ c, 7);
      return {a, b, c, d};
   endfunction

   function automatic logic [511:0] ref_block(input logic [255:0] k, input logic [31:0] ctr,
                                              input logic [95:0] n, input int rounds);
      logic [31:0]  s [16];
      logic [31:0]  x [16];
      logic [511:0] r;
      s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
      for (int i = 0; i < 8; i++) s[4 + i] = k[32*i +: 32];
      s[12] = ctr;
      for (int j = 0; j < 3; j++) s[13 + j] = n[32*j +: 32];
      for (int i = 0; i < 16; i++) x[i] = s[i];
      for (int dr = 0; dr < rounds / 2; dr++) begin
         {x[0], x[4], x[8],  x[12]} = qr(x[0], x[4], x[8],  x[12]);
         {x[1], x[5], x[9],  x[13]} = qr(x[1], x[5], x[9],  x[13]);
         {x[2], x[6], x[10], x[14]} = qr(x[2], x[6], x[10], x[14]);
         {x[3], x[7], x[11], x[15]} = qr(x[3], x[7], x[11], x[15]);
         {x[0], x[5], x[10], x[15]} = qr(x[0], x[5], x[10], x[15]);
         {x[1], x[6], x[11], x[12]} = qr(x[1], x[6], x[11], x[12]);
         {x[2], x[7], x[8],  x[13]} = qr(x[2], x[7], x[8],  x[13]);
         {x[3], x[4], x[9],  x[14]} = qr(x[3], x[4], x[9],  x[14]);
      end
      for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + s[i];
      return r;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // present inputs while in_ready is high and return just after the accept edge
   task automatic accept(input logic [255:0] k, input logic [31:0] c, input logic [95:0] n);
      key = k; counter = c; nonce = n;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   // edges after the accept edge until out_valid is observed
   task automatic wait_out(output int edges);
      edges = 0;
      while (!out_valid && edges < 200) begin
         tick();
         edges++;
      end
      if (!out_valid) begin
         checks++; errors++;
         $display("FAIL wait_out timeout: out_valid=%b after %0d edges, required 1", out_valid, edges);
      end
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; b_in_valid = 1'b0;
      key = RFC_KEY; counter = 32'd1; nonce = RFC_NONCE;
      tick(); tick();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset in_ready: got %b required 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b required 0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b required 0", busy); end
      checks++; if (keystream !== 512'd0) begin errors++; $display("FAIL reset keystream: got %h required 0", keystream); end
      in_valid = 1'b0; rst = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset release in_ready: got %b required 1", in_ready); end
   endtask

   task automatic test_rfc_vector();
      int e;
      accept(RFC_KEY, 32'd1, RFC_NONCE);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rfc busy: got %b required 1", busy); end
      wait_out(e);
      checks++; if (e + 1 !== NR + 2) begin errors++; $display("FAIL rfc latency: got %0d required %0d", e + 1, NR + 2); end
      checks++; if (keystream !== RFC_KS) begin errors++; $display("FAIL rfc keystream: got %h required %h", keystream, RFC_KS); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rfc in_ready in DONE: got %b required 0", in_ready); end
      handshake();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL rfc after handshake: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
      end
      checks++; if (keystream !== RFC_KS) begin errors++; $display("FAIL rfc keystream retained: got %h required %h", keystream, RFC_KS); end
   endtask

   task automatic test_backpressure();
      int e;
      accept(RFC_KEY, 32'd1, RFC_NONCE);
      wait_out(e);
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b1 || keystream !== RFC_KS || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL backpressure hold %0d: out_valid=%b in_ready=%b ks=%h required 1/0/%h",
                     i, out_valid, in_ready, keystream, RFC_KS);
         end
      end
      handshake();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL backpressure release: out_valid=%b in_ready=%b busy=%b required 0/1/0", out_valid, in_ready, busy);
      end
   endtask

   task automatic test_busy_input();
      int e;
      int seen;
      accept(RFC_KEY, 32'd1, RFC_NONCE);
      repeat (4) tick();
      key = {8{$urandom}}; counter = 32'h0000_0077; nonce = {3{$urandom}};
      in_valid = 1'b1;
      repeat (3) tick();
      in_valid = 1'b0;
      key = ~RFC_KEY;
      wait_out(e);
      checks++; if (keystream !== RFC_KS) begin errors++; $display("FAIL busy_input keystream: got %h required %h", keystream, RFC_KS); end
      handshake();
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (out_valid || busy) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL busy_input second block: got %0d active cycles required 0", seen); end
   endtask

   task automatic test_mid_reset();
      int e;
      accept(RFC_KEY, 32'd1, RFC_NONCE);
      repeat (6) tick();
      rst = 1'b1;
      tick();
      checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
         errors++; $display("FAIL mid_reset state: busy=%b out_valid=%b in_ready=%b required 0/0/0", busy, out_valid, in_ready);
      end
      rst = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset in_ready: got %b required 1", in_ready); end
      accept(RFC_KEY, 32'd1, RFC_NONCE);
      wait_out(e);
      checks++; if (keystream !== RFC_KS) begin errors++; $display("FAIL mid_reset rerun: got %h required %h", keystream, RFC_KS); end
      handshake();
   endtask

   task automatic test_back_to_back();
      logic [255:0] k;
      logic [95:0]  n;
      logic [511:0] ks1;
      bit           got1;
      int           e, acc2;
      k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      n = {$urandom, $urandom, $urandom};
      out_ready = 1'b1;
      key = k; nonce = n; counter = 32'd1;
      in_valid = 1'b1;
      tick();
      counter = 32'd2;
      got1 = 1'b0; acc2 = -1; ks1 = '0;
      for (e = 1; e < 60; e++) begin
         tick();
         if (out_valid && !got1) begin ks1 = keystream; got1 = 1'b1; end
         if (in_ready) begin acc2 = e + 1; break; end
      end
      tick();
      in_valid = 1'b0;
      checks++; if (acc2 !== NR + 3) begin errors++; $display("FAIL b2b accept spacing: got %0d required %0d", acc2, NR + 3); end
      checks++; if (!got1 || ks1 !== ref_block(k, 32'd1, n, NR)) begin
         errors++; $display("FAIL b2b block1: got %h required %h", ks1, ref_block(k, 32'd1, n, NR));
      end
      wait_out(e);
      checks++; if (keystream !== ref_block(k, 32'd2, n, NR)) begin
         errors++; $display("FAIL b2b block2: got %h required %h", keystream, ref_block(k, 32'd2, n, NR));
      end
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_random();
      logic [255:0] k;
      logic [95:0]  n;
      logic [31:0]  c;
      logic [511:0] exp;
      int           e, hold;
      for (int t = 0; t < 6; t++) begin
         k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         n = {$urandom, $urandom, $urandom};
         c = $urandom;
         exp = ref_block(k, c, n, NR);
         repeat ($urandom_range(0, 2)) tick();
         accept(k, c, n);
         key = ~k;
         wait_out(e);
         hold = $urandom_range(0, 3);
         for (int h = 0; h < hold; h++) tick();
         checks++; if (out_valid !== 1'b1 || keystream !== exp) begin
            errors++; $display("FAIL random %0d: out_valid=%b ks=%h required 1/%h", t, out_valid, keystream, exp);
         end
         handshake();
      end
   endtask

   task automatic test_rounds8();
      logic [511:0] exp;
      int           e;
      exp = ref_block(RFC_KEY, 32'd1, RFC_NONCE, NR8);
      b_out_ready = 1'b0;
      key = RFC_KEY; counter = 32'd1; nonce = RFC_NONCE;
      checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL r8 in_ready: got %b required 1", b_in_ready); end
      b_in_valid = 1'b1;
      tick();
      b_in_valid = 1'b0;
      e = 0;
      while (!b_out_valid && e < 100) begin tick(); e++; end
      checks++; if (e + 1 !== NR8 + 2) begin errors++; $display("FAIL r8 latency: got %0d required %0d", e + 1, NR8 + 2); end
      checks++; if (b_keystream !== exp) begin errors++; $display("FAIL r8 keystream: got %h required %h", b_keystream, exp); end
      b_out_ready = 1'b1;
      tick();
      checks++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin
         errors++; $display("FAIL r8 handshake: out_valid=%b in_ready=%b required 0/1", b_out_valid, b_in_ready);
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      b_in_valid = 1'b0; b_out_ready = 1'b1;
      key = '0; counter = '0; nonce = '0;
      test_reset();
      test_rfc_vector();
      test_backpressure();
      test_busy_input();
      test_mid_reset();
      test_back_to_back();
      test_random();
      test_rounds8();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
